// File: rtl/pipe_hazard_sb_pkg.sv
// Shared encodings for the pipe_hazard_sb scoreboard hazard unit: instruction
// classes, forward-select codes, and the scoreboard counter width.
package pipe_hazard_sb_pkg;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_LOAD = 2'b01,
    CLS_MUL  = 2'b10,
    CLS_RSVD = 2'b11
  } cls_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;

  // Cycles until a freshly issued result becomes forwardable; reserved class acts as ALU.
  function automatic cnt_t result_lat(logic [1:0] cls, int ld_lat, int mul_lat);
    case (cls)
      CLS_LOAD: return cnt_t'(ld_lat);
      CLS_MUL:  return cnt_t'(mul_lat);
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_hazard_sb_entry.sv
// One scoreboard slot: countdown to zero, a new load overrides the decrement,
// and a flush clear overrides both.
module sb_entry
  import pipe_hazard_sb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  cnt_t load_val,
  input  logic clr,
  output cnt_t cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_sb.sv
// Scoreboard-based hazard unit: data/structural stalls, control flushes and
// Execute-stage forwarding. Define HZ_SB_STATS_EN to add stall/flush counters.
module pipe_hazard_sb
  import pipe_hazard_sb_pkg::*;
#(
  parameter int NREG    = 16,
  parameter int LD_LAT  = 1,
  parameter int MUL_LAT = 4,
  localparam int RA_W   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_d,
  input  logic [RA_W-1:0] ra1_d,
  input  logic [RA_W-1:0] ra2_d,
  input  logic            use1_d,
  input  logic            use2_d,
  input  logic [RA_W-1:0] wa_d,
  input  logic            we_d,
  input  logic [1:0]      cls_d,
  input  logic            Match_1E_M,
  input  logic            Match_1E_W,
  input  logic            Match_2E_M,
  input  logic            Match_2E_W,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  input  logic            PCSrcD,
  input  logic            PCSrcE,
  input  logic            PCSrcM,
  input  logic            PCSrcW,
  input  logic            BranchTakenE,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic            FlushE,
`ifdef HZ_SB_STATS_EN
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt,
`endif
  output logic            mul_busy
);

  cnt_t            cnt [NREG];
  cnt_t            mul_cnt;
  cnt_t            ld_val;
  logic            hz;
  logic            sz;
  logic            adv;
  logic            ex_clr;
  logic            ex_valid;
  logic            ex_we;
  logic [RA_W-1:0] ex_wa;
  logic [1:0]      ex_cls;

  assign ld_val   = result_lat(cls_d, LD_LAT, MUL_LAT);
  assign hz       = issue_d & ((use1_d & (cnt[ra1_d] != '0)) | (use2_d & (cnt[ra2_d] != '0)));
  assign mul_busy = (mul_cnt != '0);
  assign sz       = issue_d & (cls_d == CLS_MUL) & mul_busy;

  assign StallD = hz | sz;
  assign StallF = StallD | PCSrcD | PCSrcE | PCSrcM;
  assign FlushD = PCSrcD | PCSrcE | PCSrcM | PCSrcW | BranchTakenE;
  assign FlushE = StallD | BranchTakenE;

  assign adv    = issue_d & ~StallD & ~FlushD;
  // A taken branch squashes whatever entered Execute last, so its pending result never arrives.
  assign ex_clr = BranchTakenE & ex_valid;

  for (genvar i = 0; i < NREG; i++) begin : g_sb
    sb_entry u_entry (
      .clk      (clk),
      .reset    (reset),
      .load     (adv & we_d & (wa_d == RA_W'(i))),
      .load_val (ld_val),
      .clr      (ex_clr & ex_we & (ex_wa == RA_W'(i))),
      .cnt      (cnt[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_cnt <= '0;
    end else if (ex_clr && (ex_cls == CLS_MUL)) begin
      mul_cnt <= '0;
    end else if (adv && (cls_d == CLS_MUL)) begin
      mul_cnt <= cnt_t'(MUL_LAT);
    end else if (mul_cnt != '0) begin
      mul_cnt <= mul_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_we    <= 1'b0;
      ex_wa    <= '0;
      ex_cls   <= CLS_ALU;
    end else if (FlushE) begin
      ex_valid <= 1'b0;
    end else begin
      ex_valid <= adv;
      ex_we    <= we_d;
      ex_wa    <= wa_d;
      ex_cls   <= cls_d;
    end
  end

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (Match_1E_M && RegWriteM)      ForwardAE = FWD_MEM;
    else if (Match_1E_W && RegWriteW) ForwardAE = FWD_WB;
    if (Match_2E_M && RegWriteM)      ForwardBE = FWD_MEM;
    else if (Match_2E_W && RegWriteW) ForwardBE = FWD_WB;
  end

`ifdef HZ_SB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallD && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (FlushE && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/pipe_hazard_sb.md
PIPE_HAZARD_SB -- requirements
Module: pipe_hazard_sb

Interface
REQ-001 SHALL have parameter NREG, default 16: number of architectural registers; RA_W = $clog2(NREG).
REQ-002 SHALL have parameter LD_LAT, default 1, range 1..3: stall cycles a load result is unavailable to a dependent in Decode.
REQ-003 SHALL have parameter MUL_LAT, default 4, range 1..8: multiply result latency and non-pipelined multiplier occupancy, in cycles.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 issue_d  in  1  valid instruction held in Decode.
REQ-007 ra1_d, ra2_d  in  RA_W  Decode source register addresses; use1_d, use2_d  in  1  source actually read.
REQ-008 wa_d  in  RA_W  Decode destination; we_d  in  1  writes register; cls_d  in  2  00 ALU, 01 LOAD, 10 MUL, 11 reserved (treated as ALU).
REQ-009 Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W  in  1  each  Execute-source vs Memory/Writeback-destination address matches.
REQ-010 RegWriteM, RegWriteW  in  1  each  write enables of the Memory and Writeback stages.
REQ-011 PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  each  PC-writing instruction in that stage; BranchTakenE  in  1  branch resolved taken in Execute.
REQ-012 ForwardAE, ForwardBE  out  2  each  00 register file, 01 Writeback result, 10 Memory result.
REQ-013 StallF, StallD, FlushD, FlushE  out  1  each  pipeline control.
REQ-014 mul_busy  out  1  multiplier occupied.

Function
REQ-015 Scoreboard: each register r SHALL hold cnt[r] (4 bits) = remaining cycles until result is forwardable; 0 = no hazard.
REQ-016 Advance condition adv = issue_d & ~StallD & ~FlushD; on adv with we_d, cnt[wa_d] SHALL load 0 for ALU, LD_LAT for LOAD and MUL_LAT for MUL.
REQ-017 Every other nonzero cnt SHALL decrement by 1 each cycle; when a load and a decrement hit the same entry in one cycle, the load wins (WAW overwrite).
REQ-018 Data stall: hz = issue_d & ((use1_d & cnt[ra1_d]!=0) | (use2_d & cnt[ra2_d]!=0)).
REQ-019 Structural stall: sz = issue_d & cls_d==MUL & mul_busy; the multiplier counter SHALL load MUL_LAT on MUL advance and decrement to 0; mul_busy = (counter != 0).
REQ-020 StallD = hz | sz; StallF = StallD | PCSrcD | PCSrcE | PCSrcM.
REQ-021 FlushD = PCSrcD | PCSrcE | PCSrcM | PCSrcW | BranchTakenE; FlushE = StallD | BranchTakenE.
REQ-022 Execute tracker SHALL register {valid, wa, cls} of the instruction entering Execute (cleared on FlushE); on BranchTakenE the flushed Execute entry's cnt SHALL be cleared to 0 and, if it was MUL, the multiplier counter cleared.
REQ-023 Forwarding: ForwardAE = 10 if Match_1E_M & RegWriteM, else 01 if Match_1E_W & RegWriteW, else 00; ForwardBE identical using Match_2E_*; Memory priority on double match.
REQ-024 Latency: an ALU-produced source SHALL never stall; a LOAD dependent issued directly after SHALL stall exactly LD_LAT cycles; a MUL dependent exactly MUL_LAT cycles.
REQ-025 Stall-cycle and flush-cycle precedence: BranchTakenE clears dependency state in the same edge as any decrement; no advance occurs that cycle.

Reset
REQ-026 reset SHALL clear all cnt entries, multiplier counter, Execute tracker and statistic counters asynchronously.
REQ-027 With inputs idle during/after reset, all outputs SHALL read 0; reset mid-stall SHALL release StallD immediately.

Configuration
REQ-028 Macro HZ_SB_STATS_EN defined: adds outputs stall_cnt (32, counts cycles with StallD=1) and flush_cnt (32, counts cycles with FlushE=1), saturating at all-ones; undefined: ports and counters absent, other behaviour identical.

Structure
REQ-029 Shared package SHALL hold instruction class encodings (ALU/LOAD/MUL), forward-select encodings (00/01/10) and counter width constant.
REQ-030 One sub-module sb_entry (per-register countdown with load-priority) SHALL be instantiated NREG times.

Verification
REQ-031 LDR r2 advances, then ADD r3,r2,r1 in Decode (LD_LAT=1) -> StallD=StallF=FlushE=1 one cycle, then advance; with LD_LAT=3 -> exactly 3 stall cycles.
REQ-032 MUL r4 then MUL r5 (MUL_LAT=4) -> second MUL stalls 4 cycles on mul_busy; dependent ADD on r4 stalls 4 cycles.
REQ-033 Match_1E_M=1, Match_1E_W=1, RegWriteM=RegWriteW=1 -> ForwardAE=10; RegWriteM=0 -> 01; all 0 -> 00.
REQ-034 LDR r6 in Execute with BranchTakenE=1 -> FlushD=FlushE=1, cnt[6] cleared, next-cycle reader of r6 does not stall.
REQ-035 PCSrcD=1 -> StallF=1, FlushD=1 until PCSrcW deasserts (4 cycles total FlushD).
REQ-036 reset asserted mid-MUL stall -> mul_busy=0, StallD=0 same cycle; HZ_SB_STATS_EN build: 3 stall cycles -> stall_cnt=3.
